// File: rtl/sys_array_pkg.sv
// sys_array_pkg: shared types and helpers for the systolic-array result path.
// Holds the collector FSM encoding, the result element type and the skew helper.
`default_nettype none

package sys_array_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_LATENCY    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } collect_state_t;

  typedef logic [2*DEF_DATA_WIDTH-1:0] result_t;

  // Row of C whose column j element leaves the array at count t.
  function automatic int skew_row(input int t, input int j, input int lat = DEF_LATENCY);
    return t - lat - j;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sys_array_row_buffer.sv
// sys_array_row_buffer: full C-matrix store with per-row complete flags.
// Columns are written independently; a row becomes readable once its last column lands.
`default_nettype none

module sys_array_row_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ARRAY_A_W  = 5,
  parameter int ARRAY_W_L  = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [ARRAY_W_L-1:0]           wr_en,
  input  logic [$clog2(ARRAY_A_W)-1:0]   wr_row  [0:ARRAY_W_L-1],
  input  logic [2*DATA_WIDTH-1:0]        wr_data [0:ARRAY_W_L-1],
  input  logic                           rd_accept,
  output logic                           rd_valid,
  output logic [$clog2(ARRAY_A_W)-1:0]   rd_idx,
  output logic [2*DATA_WIDTH-1:0]        rd_data [0:ARRAY_W_L-1]
);

  localparam int RW = $clog2(ARRAY_A_W);

  logic [2*DATA_WIDTH-1:0] mem_q [0:ARRAY_A_W-1][0:ARRAY_W_L-1];
  logic [ARRAY_A_W-1:0]    complete_q, complete_d;
  logic [RW-1:0]           rp_q, rp_d;

  always_ff @(posedge clk) begin
    for (int j = 0; j < ARRAY_W_L; j++) begin
      if (wr_en[j]) begin
        mem_q[wr_row[j]][j] <= wr_data[j];
      end
    end
  end

  // A row never completes while it is the one being read out, so set and clear cannot collide.
  always_comb begin
    complete_d = complete_q;
    rp_d       = rp_q;
    if (rd_accept) begin
      complete_d[rp_q] = 1'b0;
      rp_d = (rp_q == RW'(ARRAY_A_W - 1)) ? '0 : rp_q + RW'(1);
    end
    if (wr_en[ARRAY_W_L-1]) begin
      complete_d[wr_row[ARRAY_W_L-1]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      complete_q <= '0;
      rp_q       <= '0;
    end else begin
      complete_q <= complete_d;
      rp_q       <= rp_d;
    end
  end

  assign rd_valid = complete_q[rp_q];
  assign rd_idx   = rp_q;

  for (genvar j = 0; j < ARRAY_W_L; j++) begin : g_rd
    assign rd_data[j] = rd_valid ? mem_q[rp_q][j] : '0;
  end

endmodule

`default_nettype wire

// File: rtl/sys_array_output_collector.sv
// sys_array_output_collector: de-skews the array's bottom-row stream into whole C rows
// and hands them out one per valid/ready transfer.
`default_nettype none

module sys_array_output_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int ARRAY_A_W  = 5,
  parameter int ARRAY_W_L  = 4,
  parameter int LATENCY    = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [2*DATA_WIDTH-1:0]        array_out [0:ARRAY_W_L-1],
  output logic [2*DATA_WIDTH-1:0]        row_data  [0:ARRAY_W_L-1],
  output logic [$clog2(ARRAY_A_W)-1:0]   row_idx,
  output logic                           row_valid,
  input  logic                           row_ready,
  output logic                           busy,
  output logic                           done
);

  import sys_array_pkg::*;

  localparam int RW     = $clog2(ARRAY_A_W);
  localparam int LAST_T = LATENCY + ARRAY_A_W + ARRAY_W_L - 2;
  localparam int TW     = $clog2(LAST_T + 1) + 1;

  collect_state_t        state_q;
  logic [TW-1:0]         t_q, t_d;
  logic                  busy_q, done_q, fin_q;
  logic [ARRAY_W_L-1:0]  wr_en;
  logic [RW-1:0]         wr_row [0:ARRAY_W_L-1];
  logic                  rd_accept, last_accept;

  // t_q holds the number of edges since start was sampled; t_d is the count at the coming edge.
  assign t_d = t_q + TW'(1);

  for (genvar j = 0; j < ARRAY_W_L; j++) begin : g_col
    int r;
    assign r         = skew_row(int'(t_d), j, LATENCY);
    assign wr_en[j]  = (state_q == COLLECT) && (r >= 0) && (r < ARRAY_A_W);
    assign wr_row[j] = RW'(r);
  end

  assign rd_accept   = row_valid && row_ready;
  assign last_accept = rd_accept && (row_idx == RW'(ARRAY_A_W - 1));

  // fin_q delays the done pulse and busy release by one edge after the final hand-off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (fin_q) begin
        fin_q  <= 1'b0;
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start && !busy_q) begin
            state_q <= COLLECT;
            t_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        COLLECT: begin
          t_q <= t_d;
          if (t_d == TW'(LAST_T)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_accept) begin
            state_q <= IDLE;
            fin_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  sys_array_row_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ARRAY_A_W  (ARRAY_A_W),
    .ARRAY_W_L  (ARRAY_W_L)
  ) u_row_buffer (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_data   (array_out),
    .rd_accept (rd_accept),
    .rd_valid  (row_valid),
    .rd_idx    (row_idx),
    .rd_data   (row_data)
  );

endmodule

`default_nettype wire

// File: doc/sys_array_output_collector.md
# sys_array_output_collector

Result-side companion of `sys_array_basic`. Samples the diagonally skewed partial-sum stream leaving the array's bottom row and reassembles it into whole rows of the result matrix C (ARRAY_A_W × ARRAY_W_L). Delivers those rows one at a time over a valid/ready handshake. Sits between the array's `output_data` bus and any downstream consumer (memory writer, host bench).

## Interface
- `DATA_WIDTH`, 16, operand width; result elements are 2*DATA_WIDTH.
- `ARRAY_A_W`, 5, rows of input matrix A = rows of C.
- `ARRAY_W_L`, 4, columns of weight matrix = columns of C.
- `LATENCY`, 4, cycles from the `start` edge to C[0][0] being valid on column 0.
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  pulse on the edge where A row 0 / column 0 enters the array.
- `array_out`  in  [2*DATA_WIDTH-1:0] [0:ARRAY_W_L-1]  array column outputs.
- `row_data`  out  [2*DATA_WIDTH-1:0] [0:ARRAY_W_L-1]  assembled C row.
- `row_idx`  out  $clog2(ARRAY_A_W) bits  index of the row on `row_data`.
- `row_valid`  out  1  `row_data`/`row_idx` valid.
- `row_ready`  in  1  consumer accepts the row.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle pulse after the last row is accepted.

## Operation
- States: IDLE, COLLECT, DRAIN.
- IDLE: `start` high → COLLECT. The cycle counter `t` clears to 0 and `busy` goes to 1.
- COLLECT: `t` increments every cycle. At count t, for each column j, compute r = t − LATENCY − j. If 0 ≤ r < ARRAY_A_W, capture `array_out[j]` into buffer[r][j]. Otherwise ignore the column.
- Row r is complete once column ARRAY_W_L−1 has been captured for it. A per-row complete flag is set at that point.
- When t = LATENCY + ARRAY_A_W + ARRAY_W_L − 2 (the last capture), COLLECT → DRAIN.
- Output stream:
  - A read pointer `rp` starts at 0.
  - `row_valid` = complete[rp].
  - On `row_valid && row_ready`: clear complete[rp] and increment `rp`.
  - Streaming runs concurrently in COLLECT and DRAIN.
- DRAIN → IDLE on acceptance of row ARRAY_A_W−1. `done` pulses for 1 cycle on the following edge; `busy` drops on that same edge.
- `start` while `busy` is ignored and does not restart the job.
- Because the buffer holds the full matrix, backpressure never loses data. `row_ready` may be held low for any duration.
- Arithmetic: data passes through unchanged, with no truncation or sign handling.

## Timing
- Reset (asynchronous, any time including mid-job):
  - state IDLE, `t` = 0, `rp` = 0, all complete flags 0.
  - `row_valid` = 0, `busy` = 0, `done` = 0, `row_idx` = 0, `row_data` = 0.
- Buffer contents need no reset.
- Let `start` be sampled at edge E0. Column j of row r is sampled at edge E0 + LATENCY + r + j.
- Row r becomes valid in the cycle after edge E0 + LATENCY + r + ARRAY_W_L − 1.
- With `row_ready` held high, one row is delivered per cycle. Row 0 is first valid after edge E0+7 (defaults). The last row is accepted at edge E0+12, and `done` is high after edge E0+13.
- `row_data` and `row_idx` are stable while `row_valid && !row_ready`.
- `row_valid` is registered and is not combinationally derived from `row_ready`.

## Structure
- Shared package `sys_array_pkg` holds:
  - the `collect_state_t` enum (IDLE/COLLECT/DRAIN);
  - a `result_t` typedef (logic [2*DATA_WIDTH-1:0]) as the result element type;
  - helper function `skew_row(t, j)` returning t − LATENCY − j.
- One sub-module: `sys_array_row_buffer` holds the ARRAY_A_W×ARRAY_W_L storage with per-row complete flags and the read port.
- The FSM and counter stay in the top module.

## Test plan
- Skewed ramp: pulse `start`, drive column j with 16*r + j at edge E0+4+r+j, and hold `row_ready` = 1. Expected: rows 0..4 equal {16r, 16r+1, 16r+2, 16r+3}, `row_idx` 0..4 on consecutive cycles, first valid after E0+7, `done` after E0+13.
- Backpressure: same stimulus with `row_ready` = 0 until E0+20, then 1. Expected: all five rows intact and in order, and `row_data` does not change while stalled.
- Alternating `row_ready` (1,0,1,0…). Expected: each row is delivered exactly once, with no duplicates or skips.
- Real data: weights 1..12 (row-major 3×4), A row 0 = {1,2,3}, fed through `sys_array_basic`. Expected: row 0 = {38, 44, 50, 56}.
- Spurious `start` at E0+6. Expected: ignored, and the output is identical to the ramp test.
- Assert `reset_n` low at E0+8 for 2 cycles. Expected: `row_valid`, `busy` and `done` are 0 immediately. A new `start` then produces a clean ramp result.
